// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch_queue
// Purpose  : Instruction fetch front end. A DEPTH-entry prefetch queue of
//            {instr, pc} decouples instruction-memory latency from decode.
//            Handles branch/flush redirects, interrupt entry with a saved
//            return PC (epc), and rti/rsi returns. Responses belonging to
//            requests issued before a redirect are counted and discarded.
// Ports    : clk, rst                     - clock, async active-high reset
//            imem_req_*_o / imem_req_ready_i, imem_addr_o
//                                         - fetch request channel
//            imem_rsp_valid_i, imem_rsp_data_i
//                                         - in-order fetch responses
//            redirect_valid_i, redirect_pc_i, irq_i, rti_i, rsi_i
//                                         - control-flow events
//            dec_*_o, dec_ready_i         - queue head towards decode
//            in_irq_o, epc_o              - interrupt state
// Revision : 1.0 - initial release
// ============================================================================
module fetch_prefetch_queue #(
   parameter int unsigned     XLEN       = 32,
   parameter int unsigned     DEPTH      = 4,
   parameter int unsigned     MAX_OUTST  = 2,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter logic [XLEN-1:0] IRQ_VECTOR = XLEN'(32'h0000_0004)
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid_o,
   input  logic            imem_req_ready_i,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_rsp_valid_i,
   input  logic [XLEN-1:0] imem_rsp_data_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            irq_i,
   input  logic            rti_i,
   input  logic            rsi_i,
   output logic            dec_valid_o,
   input  logic            dec_ready_i,
   output logic [XLEN-1:0] dec_instr_o,
   output logic [XLEN-1:0] dec_pc_o,
   output logic [XLEN-1:0] dec_pc_next_o,
   output logic            dec_is_load_o,
   output logic            in_irq_o,
   output logic [XLEN-1:0] epc_o
);

   localparam int unsigned     CW        = $clog2(DEPTH) + 1;
   localparam int unsigned     AW        = $clog2(DEPTH);
   localparam int unsigned     IW        = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

   localparam logic [0:0] ST_RUN        = 1'b0;
   localparam logic [0:0] ST_IRQ_ACTIVE = 1'b1;

   // ---------------------------------------------------------------- state
   logic [0:0]      state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   outst_q, outst_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [IW-1:0]   fl_rd_q, fl_rd_d;
   logic [IW-1:0]   fl_wr_q, fl_wr_d;

   logic [XLEN-1:0] q_instr_q [DEPTH];
   logic [XLEN-1:0] q_pc_q    [DEPTH];
   logic [XLEN-1:0] fl_pc_q   [MAX_OUTST];   // PCs of requests still in flight

   // ---------------------------------------------------------------- decode
   logic            irq_take, rti_take, rsi_take, redir_take, evt;
   logic            rsp, drop_rsp, push, pop, hs, credit_ok;
   logic            head_valid;
   logic [XLEN-1:0] head_pc, rsp_instr, resume_pc;
   logic [CW:0]     inflight_sum;

   function automatic logic [IW-1:0] fl_inc(input logic [IW-1:0] p);
      fl_inc = (p == IW'(MAX_OUTST - 1)) ? '0 : p + IW'(1);
   endfunction

   // One event per cycle; an irq while the handler is running is not an event.
   assign irq_take   = irq_i && (state_q == ST_RUN);
   assign rti_take   = !irq_take && rti_i;
   assign rsi_take   = !irq_take && !rti_i && rsi_i;
   assign redir_take = !irq_take && !rti_i && !rsi_i && redirect_valid_i;
   assign evt        = irq_take || rti_take || rsi_take || redir_take;

   // A response with nothing in flight is a leftover from before reset.
   assign rsp      = imem_rsp_valid_i && (outst_q != '0);
   assign drop_rsp = rsp && (drop_q != '0);
   assign push     = rsp && !drop_rsp && !evt;

   assign head_valid = (count_q != '0);
   assign head_pc    = head_valid ? q_pc_q[rd_ptr_q] : '0;
   assign pop        = head_valid && dec_ready_i && !evt;

   // Entries held plus entries promised must fit, so the queue cannot overrun.
   assign inflight_sum = {1'b0, count_q} + {1'b0, outst_q};
   assign credit_ok    = (inflight_sum < (CW+1)'(DEPTH)) && (outst_q < CW'(MAX_OUTST));

   assign imem_req_valid_o = !rst && !evt && credit_ok;
   assign hs               = imem_req_valid_o && imem_req_ready_i;

   assign rsp_instr = ($isunknown(imem_rsp_data_i) || (imem_rsp_data_i == '0))
                      ? NOP_INSTR : imem_rsp_data_i;

   // With the queue empty, the next instruction to execute is the oldest
   // in-flight request that will not be discarded.
   assign resume_pc = fetch_pc_q - (XLEN'(outst_q - drop_q) << 2);

   // ---------------------------------------------------------------- next state
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      epc_d      = epc_q;
      count_d    = count_q + CW'(push) - CW'(pop);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      wr_ptr_d   = wr_ptr_q + AW'(push);
      outst_d    = outst_q + CW'(hs) - CW'(rsp);
      drop_d     = drop_rsp ? drop_q - CW'(1) : drop_q;
      fl_wr_d    = hs  ? fl_inc(fl_wr_q) : fl_wr_q;
      fl_rd_d    = rsp ? fl_inc(fl_rd_q) : fl_rd_q;

      if (evt) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         // Everything still in flight after this cycle belongs to the old stream.
         drop_d   = outst_q - CW'(rsp);
      end

      if (irq_take) begin
         fetch_pc_d = IRQ_VECTOR;
         if (redirect_valid_i)
            epc_d = redirect_pc_i;
         else if (head_valid)
            epc_d = head_pc;
         else
            epc_d = resume_pc;
      end else if (rti_take) begin
         fetch_pc_d = epc_q;
      end else if (rsi_take) begin
         fetch_pc_d = redirect_pc_i;
         // Outside a handler rsi is a plain redirect and keeps epc.
         if (state_q == ST_IRQ_ACTIVE)
            epc_d = '0;
      end else if (redir_take) begin
         fetch_pc_d = redirect_pc_i;
      end else if (hs) begin
         fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_RUN;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:        if (irq_take)          state_d = ST_IRQ_ACTIVE;
         ST_IRQ_ACTIVE: if (rti_i || rsi_i)    state_d = ST_RUN;
         default:                              state_d = ST_RUN;
      endcase
   end

   always_comb begin
      in_irq_o = (state_q == ST_IRQ_ACTIVE);
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         epc_q      <= '0;
         count_q    <= '0;
         outst_q    <= '0;
         drop_q     <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         fl_rd_q    <= '0;
         fl_wr_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         epc_q      <= epc_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         fl_rd_q    <= fl_rd_d;
         fl_wr_q    <= fl_wr_d;
      end
   end

   // Storage is qualified by the counters, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         q_instr_q[wr_ptr_q] <= rsp_instr;
         q_pc_q[wr_ptr_q]    <= fl_pc_q[fl_rd_q];
      end
      if (hs)
         fl_pc_q[fl_wr_q] <= fetch_pc_q;
   end

   // ---------------------------------------------------------------- outputs
   assign imem_addr_o   = fetch_pc_q;
   assign dec_valid_o   = head_valid;
   assign dec_instr_o   = head_valid ? q_instr_q[rd_ptr_q] : NOP_INSTR;
   assign dec_pc_o      = head_pc;
   assign dec_pc_next_o = head_pc + XLEN'(4);
   assign dec_is_load_o = head_valid && (dec_instr_o[6:0] == 7'b0000011);
   assign epc_o         = epc_q;

endmodule
`default_nettype wire
